systolic_gemm_os: RTL and testbench
===================================

Name: systolic_gemm_os

Overview:
- Parametrised output-stationary systolic matrix-multiply engine. It computes C[ROWS][COLS] = A[ROWS][K] x B[K][COLS] in signed fixed point.
- Contains its own input skew registers, a per-job control FSM, valid/ready operand and result handshakes, and row-by-row result drain.
- Successor to the fixed 4x4, externally sequenced PE array. External per-PE control words are no longer needed.
- Sits between the operand buffers and the activation/writeback stage.

Parameters:
WIDTH, 8, operand and result bit width (signed two's complement)
DECIMAL, 4, fractional bits of operands and results
ROWS, 4, array rows (A channels, result rows)
COLS, 4, array columns (B channels, result columns)
MAX_K, 256, largest supported inner dimension
KW, 9, width of k_len; must satisfy 2**KW > MAX_K

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  job start; sampled only in IDLE
k_len  in  KW  inner dimension K (0..MAX_K); sampled with start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last result row is accepted
a_valid  in  1  operand beat valid
a_ready  out  1  operand beat accepted when a_valid&&a_ready
a_data  in  ROWS*WIDTH  A column k; lane r = A[r][k]
b_data  in  COLS*WIDTH  B row k; lane c = B[k][c]; shares a_valid/a_ready
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts row
out_data  out  COLS*WIDTH  result row; lane c = C[out_row][c]
out_row  out  clog2(ROWS)  index of the row on out_data
sat_flag  out  1  sticky per job; set if any result saturated; cleared on start

Behaviour:
- Reset (rst low, async): FSM to IDLE; all skew registers, valid tags and accumulators cleared. busy, done, a_ready, out_valid and sat_flag are 0; out_data and out_row are 0.
- FSM states: IDLE, FEED, FLUSH, DRAIN.
- IDLE:
  - start=1 moves to FEED and clears the accumulators, sat_flag and the beat counter.
  - If k_len=0, the FSM goes straight to DRAIN and outputs all-zero rows.
- FEED:
  - a_ready=1; beat counter increments per accepted beat.
  - When beat K is accepted, the FSM moves to FLUSH (a_ready is low from the next cycle).
  - Gaps in a_valid are legal and insert bubbles.
- FLUSH:
  - Lasts exactly ROWS+COLS-1 cycles, counted from the cycle after the last beat.
  - Guarantees the last tagged operand has reached PE(ROWS-1,COLS-1), then moves to DRAIN.
- DRAIN:
  - Rows are presented in order 0..ROWS-1; out_valid=1.
  - out_row and out_data stay stable while out_valid && !out_ready.
  - Each handshake advances the row index.
  - After row ROWS-1 is accepted: done=1 for one cycle, go to IDLE, busy=0 in the same cycle as done.
- start while not in IDLE is ignored.
- Skew:
  - A lane r is delayed r cycles; B lane c is delayed c cycles.
  - Each delay stage carries data plus a valid tag; bubbles propagate as tag=0.
  - A moves right one PE per cycle; B moves down one PE per cycle.
  - PE(r,c) accumulates only when its incoming A tag is 1. The B tag is identical by construction; the assertion checks a_tag==b_tag at every PE.
- Arithmetic:
  - Product is full 2*WIDTH signed.
  - Accumulator width ACC_W = 2*WIDTH + clog2(MAX_K+1), which has no internal overflow.
  - Result = acc >>> DECIMAL (arithmetic shift, truncation toward -inf), saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Saturation is computed in the drain path; sat_flag is set on the handshake of the offending row.
- Latency with no bubbles or backpressure: first out_valid arrives K+ROWS+COLS cycles after the start cycle.
- Reset mid-job: immediate abort to the reset state. No done pulse; partial results are discarded.
- Simultaneous out_ready and the final row: done asserts on the following cycle, and start is accepted no earlier than the cycle after done.

Decomposition:
- Shared package contains:
  - the state enum: IDLE, FEED, FLUSH, DRAIN;
  - an ACC_W calculation function;
  - a signed shift-and-saturate function returning {sat, value}.
- Sub-module sa_mac_pe holds one operand-forwarding and accumulate element:
  - inputs: a, a_tag, b, b_tag, clr;
  - outputs: registered a, a_tag, b, b_tag, and acc.
- The top level has a generate grid of sa_mac_pe instances, the skew shift registers, the FSM and counters, and the drain mux.

Test Plan:
- Basic, K=1: a_data={0x40,0x30,0x20,0x10} (lanes 3..0 = 4,3,2,1), b_data all 0x10 (1.0) -> rows 0..3 = all lanes 0x10, 0x20, 0x30, 0x40; sat_flag=0; first out_valid 9 cycles after start.
- Accumulate/negative, K=3: every beat a lanes=0xF0 (-1.0), b lanes=0x10 -> every result 0xD0 (-3.0); a beat with a=0x08 and b=0x08 (0.5*0.5) -> 0x04.
- Saturation, K=4: a=b=0x70 (7.0) -> 196.0 -> all results 0x7F, sat_flag=1. Same with b=0x90 (-7.0) -> 0x80.
- Bubbles and backpressure: the basic case with a_valid low for 3 cycles between beats and out_ready low 5 cycles on row 1 -> identical data; row 1 held stable; done exactly once.
- Control: start pulsed during FEED is ignored; k_len=0 gives 4 zero rows then done; rst low mid-FLUSH -> all outputs 0 within the same cycle, a new job afterwards gives correct results.

Source files
------------

// File: rtl/systolic_gemm_os_pkg.sv
// Shared types and arithmetic helpers for the output-stationary GEMM array.
package systolic_gemm_os_pkg;
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_e;

  localparam int SAT_W = 64;

  // Accumulator wide enough that MAX_K full-width products never overflow.
  function automatic int acc_w(input int width, input int max_k);
    return 2*width + $clog2(max_k+1);
  endfunction

  // Arithmetic shift right by dec, clamp to a signed width-bit range; returns {sat, value}.
  function automatic logic [SAT_W:0] shift_sat(input logic signed [SAT_W-1:0] acc,
                                               input int width, input int dec);
    logic signed [SAT_W-1:0] sh, hi, lo;
    sh = acc >>> dec;
    hi = (64'sd1 <<< (width-1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sh > hi) return {1'b1, hi};
    if (sh < lo) return {1'b1, lo};
    return {1'b0, sh};
  endfunction
endpackage

// File: rtl/systolic_gemm_os_if.sv
// Job control, operand stream and result stream of the GEMM engine.
interface systolic_gemm_os_if #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int KW    = 9,
  parameter int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
);
  logic                         start;
  logic [KW-1:0]                k_len;
  logic                         busy;
  logic                         done;
  logic                         a_valid;
  logic                         a_ready;
  logic [ROWS-1:0][WIDTH-1:0]   a_data;
  logic [COLS-1:0][WIDTH-1:0]   b_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [COLS-1:0][WIDTH-1:0]   out_data;
  logic [RW-1:0]                out_row;
  logic                         sat_flag;

  modport master (output start, k_len, a_valid, a_data, b_data, out_ready,
                  input  busy, done, a_ready, out_valid, out_data, out_row, sat_flag);
  modport slave  (input  start, k_len, a_valid, a_data, b_data, out_ready,
                  output busy, done, a_ready, out_valid, out_data, out_row, sat_flag);
endinterface

// File: rtl/systolic_gemm_os_pe.sv
// One array element: forwards A right and B down, accumulates A*B when tagged.
module sa_mac_pe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic signed [WIDTH-1:0] a,
  input  logic                    a_tag,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    b_tag,
  output logic signed [WIDTH-1:0] a_q,
  output logic                    a_tag_q,
  output logic signed [WIDTH-1:0] b_q,
  output logic                    b_tag_q,
  output logic signed [ACC_W-1:0] acc_q
);
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_d;

  always_comb begin
    prod  = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    acc_d = acc_q;
    if (clr)        acc_d = '0;
    else if (a_tag) acc_d = acc_q + (ACC_W)'(prod);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0; a_tag_q <= 1'b0; b_q <= '0; b_tag_q <= 1'b0; acc_q <= '0;
    end else begin
      a_q <= a; a_tag_q <= a_tag; b_q <= b; b_tag_q <= b_tag; acc_q <= acc_d;
    end
  end

  // Skew depths make both operands of a beat meet here in the same cycle.
  tag_align: assert property (@(posedge clk) disable iff (!rst) a_tag == b_tag);
endmodule

// File: rtl/systolic_gemm_os.sv
// Output-stationary systolic GEMM: skewed operand feed, PE grid, job FSM, row drain.
module systolic_gemm_os import systolic_gemm_os_pkg::*; #(
  parameter int WIDTH   = 8,
  parameter int DECIMAL = 4,
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int MAX_K   = 256,
  parameter int KW      = 9
) (
  input logic               clk,
  input logic               rst,
  systolic_gemm_os_if.slave bus
);
  localparam int ACC_W = acc_w(WIDTH, MAX_K);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d, cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic          sat_q, sat_d, done_q, done_d, clr, beat;

  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] a_h, b_v;
  logic [ROWS-1:0][COLS-1:0]            at_h, bt_v;
  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] acc;
  logic [COLS-1:0][WIDTH-1:0]           row_data;
  logic [COLS-1:0]                      row_sat;

  assign beat = (state_q == FEED) && bus.a_valid;

  always_comb begin
    state_d = state_q; k_d = k_q; cnt_d = cnt_q; row_d = row_q;
    sat_d = sat_q; done_d = 1'b0; clr = 1'b0;
    case (state_q)
      // The done cycle is still IDLE but must not accept a new job.
      IDLE: if (bus.start && !done_q) begin
        clr = 1'b1; sat_d = 1'b0; cnt_d = '0; row_d = '0; k_d = bus.k_len;
        state_d = (bus.k_len == '0) ? DRAIN : FEED;
      end
      FEED: if (beat) begin
        cnt_d = cnt_q + KW'(1);
        if (cnt_d == k_q) begin state_d = FLUSH; cnt_d = '0; end
      end
      FLUSH: begin
        cnt_d = cnt_q + KW'(1);
        if (cnt_q == KW'(ROWS+COLS-2)) begin state_d = DRAIN; cnt_d = '0; end
      end
      DRAIN: if (bus.out_ready) begin
        sat_d = sat_q | (|row_sat);
        if (row_q == RW'(ROWS-1)) begin state_d = IDLE; done_d = 1'b1; row_d = '0; end
        else row_d = row_q + RW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE; k_q <= '0; cnt_q <= '0; row_q <= '0; sat_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q <= state_d; k_q <= k_d; cnt_q <= cnt_d; row_q <= row_d; sat_q <= sat_d; done_q <= done_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.a_ready   = (state_q == FEED);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_row   = row_q;
  assign bus.out_data  = bus.out_valid ? row_data : '0;
  assign bus.sat_flag  = sat_q;

  // A lane r enters r cycles late, B lane c enters c cycles late; bubbles travel as tag 0.
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    if (r == 0) begin : g_direct
      assign a_h[0][0] = bus.a_data[0]; assign at_h[0][0] = beat;
    end else begin : g_dly
      logic [r-1:0][WIDTH-1:0] d_q, d_d;
      logic [r-1:0]            t_q, t_d;
      always_comb begin
        d_d = d_q << WIDTH; d_d[0] = bus.a_data[r];
        t_d = t_q << 1;     t_d[0] = beat;
      end
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin d_q <= '0; t_q <= '0; end
        else      begin d_q <= d_d; t_q <= t_d; end
      assign a_h[r][0] = d_q[r-1]; assign at_h[r][0] = t_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    if (c == 0) begin : g_direct
      assign b_v[0][0] = bus.b_data[0]; assign bt_v[0][0] = beat;
    end else begin : g_dly
      logic [c-1:0][WIDTH-1:0] d_q, d_d;
      logic [c-1:0]            t_q, t_d;
      always_comb begin
        d_d = d_q << WIDTH; d_d[0] = bus.b_data[c];
        t_d = t_q << 1;     t_d[0] = beat;
      end
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin d_q <= '0; t_q <= '0; end
        else      begin d_q <= d_d; t_q <= t_d; end
      assign b_v[0][c] = d_q[c-1]; assign bt_v[0][c] = t_q[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [WIDTH-1:0] a_o, b_o;
      logic             at_o, bt_o;
      sa_mac_pe #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_pe (
        .clk(clk), .rst(rst), .clr(clr),
        .a(a_h[r][c]), .a_tag(at_h[r][c]), .b(b_v[r][c]), .b_tag(bt_v[r][c]),
        .a_q(a_o), .a_tag_q(at_o), .b_q(b_o), .b_tag_q(bt_o), .acc_q(acc[r][c])
      );
      if (c < COLS-1) begin : g_fwd_a
        assign a_h[r][c+1] = a_o; assign at_h[r][c+1] = at_o;
      end else begin : g_edge_a
        logic [WIDTH:0] a_unused;
        assign a_unused = {at_o, a_o};
      end
      if (r < ROWS-1) begin : g_fwd_b
        assign b_v[r+1][c] = b_o; assign bt_v[r+1][c] = bt_o;
      end else begin : g_edge_b
        logic [WIDTH:0] b_unused;
        assign b_unused = {bt_o, b_o};
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_sat
    logic [SAT_W:0] res;
    assign res         = shift_sat(SAT_W'(signed'(acc[row_q][c])), WIDTH, DECIMAL);
    assign row_data[c] = res[WIDTH-1:0];
    assign row_sat[c]  = res[SAT_W];
    fits: assert property (@(posedge clk) disable iff (!rst)
      res[SAT_W-1:WIDTH-1] == {(SAT_W-WIDTH+1){res[WIDTH-1]}});
  end
endmodule

// File: tb/tb_systolic_gemm_os.sv
// Directed bench for systolic_gemm_os: hand-computed Q4.4 results, timing and control corners.
module tb_systolic_gemm_os;
  logic clk, rst;
  int   checks = 0, errors = 0, cyc = 0, ts = 0, lat = 0, done_cnt = 0, d0 = 0;
  logic [3:0][7:0] av [8];
  logic [3:0][7:0] bv [8];
  logic [3:0][7:0] exp_row [4];

  systolic_gemm_os_if #(.WIDTH(8), .ROWS(4), .COLS(4), .KW(9)) bus ();
  systolic_gemm_os #(.WIDTH(8), .DECIMAL(4), .ROWS(4), .COLS(4), .MAX_K(256), .KW(9))
    dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic rows_all(input logic [7:0] e0, e1, e2, e3);
    exp_row[0] = {4{e0}}; exp_row[1] = {4{e1}}; exp_row[2] = {4{e2}}; exp_row[3] = {4{e3}};
  endtask

  task automatic start_job(input int k);
    bus.start = 1'b1; bus.k_len = 9'(k); ts = cyc;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
  endtask

  task automatic feed(input int k, input int gap);
    for (int i = 0; i < k; i++) begin
      bus.a_valid = 1'b1; bus.a_data = av[i]; bus.b_data = bv[i];
      chk("a_ready", bus.a_ready, 1);
      tick();
      bus.a_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
    chk("a_ready_low_after_k", bus.a_ready, 0);
  endtask

  task automatic drain(input int stall_row, input int stall_n);
    int n;
    n = 0;
    d0 = done_cnt;
    while (!bus.out_valid && n < 60) begin tick(); n++; end
    chk("out_valid_wait", bus.out_valid, 1);
    lat = cyc - ts;
    for (int r = 0; r < 4; r++) begin
      if (r == stall_row) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_row", bus.out_row, r);
          chk("hold_data", bus.out_data, exp_row[r]);
        end
      end
      bus.out_ready = 1'b1;
      chk("out_row", bus.out_row, r);
      chk("out_data", bus.out_data, exp_row[r]);
      tick();
    end
    bus.out_ready = 1'b0;
    chk("done_pulse", bus.done, 1);
    chk("busy_low_at_done", bus.busy, 0);
    tick();
    chk("done_one_cycle", bus.done, 0);
    chk("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.k_len = '0; bus.a_valid = 1'b0;
    bus.a_data = '0; bus.b_data = '0; bus.out_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_a_ready", bus.a_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sat", bus.sat_flag, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_row", bus.out_row, 0);
    rst = 1'b1;
    tick();

    // K=1: rows scale with A lane, B is 1.0
    av[0] = 32'h40302010; bv[0] = 32'h10101010;
    rows_all(8'h10, 8'h20, 8'h30, 8'h40);
    start_job(1); feed(1, 0); drain(-1, 0);
    chk("basic_latency", lat, 9);
    chk("basic_sat", bus.sat_flag, 0);

    // K=3 of -1.0 * 1.0
    for (int i = 0; i < 3; i++) begin av[i] = 32'hF0F0F0F0; bv[i] = 32'h10101010; end
    rows_all(8'hD0, 8'hD0, 8'hD0, 8'hD0);
    start_job(3); feed(3, 0); drain(-1, 0);
    chk("neg_latency", lat, 11);

    // 0.5 * 0.5
    av[0] = 32'h08080808; bv[0] = 32'h08080808;
    rows_all(8'h04, 8'h04, 8'h04, 8'h04);
    start_job(1); feed(1, 0); drain(-1, 0);

    // -1/16 * 0.5 = -1/32 truncates toward -inf
    av[0] = 32'hFFFFFFFF; bv[0] = 32'h08080808;
    rows_all(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    start_job(1); feed(1, 0); drain(-1, 0);
    chk("trunc_sat", bus.sat_flag, 0);

    // Saturation high: 4 * 7.0 * 7.0
    for (int i = 0; i < 4; i++) begin av[i] = 32'h70707070; bv[i] = 32'h70707070; end
    rows_all(8'h7F, 8'h7F, 8'h7F, 8'h7F);
    start_job(4); feed(4, 0); drain(-1, 0);
    chk("sat_hi_flag", bus.sat_flag, 1);

    // Saturation low: 4 * 7.0 * -7.0
    for (int i = 0; i < 4; i++) bv[i] = 32'h90909090;
    rows_all(8'h80, 8'h80, 8'h80, 8'h80);
    start_job(4);
    chk("sat_cleared_on_start", bus.sat_flag, 0);
    feed(4, 0); drain(-1, 0);
    chk("sat_lo_flag", bus.sat_flag, 1);

    // Bubbles between beats and backpressure on row 1
    av[0] = 32'h40302010; bv[0] = 32'h10101010;
    av[1] = 32'h40302010; bv[1] = 32'h08080808;
    av[2] = 32'h00000000; bv[2] = 32'h00000000;
    rows_all(8'h18, 8'h30, 8'h48, 8'h60);
    start_job(3);
    chk("sat_cleared_again", bus.sat_flag, 0);
    feed(3, 3); drain(1, 5);
    chk("bubble_sat", bus.sat_flag, 0);

    // start during FEED is ignored; job keeps K=2
    start_job(2);
    bus.a_valid = 1'b1; bus.a_data = av[0]; bus.b_data = bv[0];
    tick();
    bus.a_valid = 1'b0; bus.start = 1'b1; bus.k_len = 9'd1;
    tick();
    bus.start = 1'b0;
    chk("feed_start_ignored", bus.a_ready, 1);
    bus.a_valid = 1'b1; bus.a_data = av[1]; bus.b_data = bv[1];
    tick();
    bus.a_valid = 1'b0;
    chk("feed_done_after_k2", bus.a_ready, 0);
    drain(-1, 0);

    // k_len=0 gives zero rows
    rows_all(8'h00, 8'h00, 8'h00, 8'h00);
    start_job(0);
    chk("k0_skips_feed", bus.a_ready, 0);
    drain(-1, 0);

    // Reset during FLUSH aborts the job immediately
    av[0] = 32'h70707070; bv[0] = 32'h70707070;
    start_job(1); feed(1, 0);
    tick();
    chk("in_flush_busy", bus.busy, 1);
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_a_ready", bus.a_ready, 0);
    chk("abort_out_data", bus.out_data, 0);
    tick(); tick();
    chk("abort_no_done", done_cnt - d0, 0);
    rst = 1'b1;
    tick();

    // Column mapping after the abort
    av[0] = 32'h10101010; bv[0] = 32'h40302010;
    for (int r = 0; r < 4; r++) exp_row[r] = 32'h40302010;
    start_job(1); feed(1, 0); drain(-1, 0);
    chk("post_reset_latency", lat, 9);
    chk("post_reset_sat", bus.sat_flag, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
